// File: rtl/ovf_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : ovf_bcd_display
// Description : Counts rising edges of an upstream overflow flag as a two-digit
//               BCD value (00..99) and drives a time-multiplexed, active-low
//               two-digit seven-segment display. It also provides a display
//               freeze (hold) and a synchronous clear.
// Ports       : clock  - sole clock, rising edge
//               reset  - asynchronous active-low reset
//               ovf_in - overflow level from the mod-12 counter
//               clear  - synchronous clear of the event count
//               hold   - freezes the displayed value; counting continues
//               ones   - live BCD units digit
//               tens   - live BCD tens digit
//               wrap   - one-cycle pulse on the 99 -> 00 rollover
//               seg    - active-low segments {g,f,e,d,c,b,a}
//               an     - active-low digit enables, an[0]=units, an[1]=tens
// Revision    : 1.0 - initial release
// ============================================================================
module ovf_bcd_display #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ovf_in,
    input  logic       clear,
    input  logic       hold,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [15:0] c_presc_last = 16'(REFRESH_DIV - 1);

    // Active-low gfedcba pattern for one BCD digit; non-BCD codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic        ovf_dly_q;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic        wrap_q, wrap_d;
    logic [3:0]  disp_ones_q, disp_ones_d;
    logic [3:0]  disp_tens_q, disp_tens_d;
    logic [15:0] presc_q, presc_d;
    logic        sel_q, sel_d;
    logic [1:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        w_event;

    // One event per rising edge of the level, however long it stays high.
    assign w_event = ovf_in & ~ovf_dly_q;

    always_comb begin
        ones_d      = ones_q;
        tens_d      = tens_q;
        wrap_d      = 1'b0;
        disp_ones_d = disp_ones_q;
        disp_tens_d = disp_tens_q;
        presc_d     = presc_q + 16'd1;
        sel_d       = sel_q;

        // Clear wins over a coincident event; that event is simply dropped.
        if (clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (w_event) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                if (tens_q == 4'd9) begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        // The latch follows the registered live count unless frozen.
        if (!hold) begin
            disp_ones_d = ones_q;
            disp_tens_d = tens_q;
        end

        if (presc_q == c_presc_last) begin
            presc_d = 16'd0;
            sel_d   = ~sel_q;
        end

        // Built from next-state values so an/seg switch together with sel
        // and track the latch without an extra cycle of lag.
        an_d  = sel_d ? 2'b01 : 2'b10;
        seg_d = seg_decode(sel_d ? disp_tens_d : disp_ones_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_dly_q   <= 1'b0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            wrap_q      <= 1'b0;
            disp_ones_q <= 4'd0;
            disp_tens_q <= 4'd0;
            presc_q     <= 16'd0;
            sel_q       <= 1'b0;
            an_q        <= 2'b10;
            seg_q       <= 7'b1000000;
        end else begin
            ovf_dly_q   <= ovf_in;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            wrap_q      <= wrap_d;
            disp_ones_q <= disp_ones_d;
            disp_tens_q <= disp_tens_d;
            presc_q     <= presc_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
    assign wrap = wrap_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
`default_nettype wire

// File: doc/ovf_bcd_display.md
OVF_BCD_DISPLAY -- requirements
Module: ovf_bcd_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 1000, clock cycles per display digit slot; legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately, independent of clock.
REQ-004 ovf_in  input  1  overflow flag from the upstream mod-12 counter; level, may stay high for more than one cycle.
REQ-005 clear  input  1  synchronous clear of the event count, active-high.
REQ-006 hold  input  1  active-high freeze of the displayed value; counting continues.
REQ-007 ones  output  4  BCD units digit of the live event count, 0..9.
REQ-008 tens  output  4  BCD tens digit of the live event count, 0..9.
REQ-009 wrap  output  1  one-cycle pulse on the 99->00 rollover.
REQ-010 seg  output  7  active-low segment drive, bit order {g,f,e,d,c,b,a}.
REQ-011 an  output  2  active-low digit enables; an[0]=units, an[1]=tens.

Function
REQ-012 ovf_in shall be registered into ovf_d every cycle; event = ovf_in & ~ovf_d, counted once per rising edge of ovf_in regardless of high duration.
REQ-013 On an event the count shall increment at the same clock edge at which ovf_d captures 1 (one-cycle latency from ovf_in rising before that edge).
REQ-014 BCD increment: ones 9 -> 0 with tens+1; otherwise ones+1, tens unchanged.
REQ-015 Rollover: at 99 an event gives 00 and wrap=1 for exactly the following cycle; wrap=0 otherwise.
REQ-016 clear shall set ones=tens=0 at the next edge and has priority over a same-cycle event; that event is discarded and wrap stays 0.
REQ-017 ovf_d shall update during clear, so an ovf_in held high through the deassertion of clear produces no event.
REQ-018 Display latch {disp_tens, disp_ones} shall load the live count every cycle hold=0 and keep its value while hold=1; live ones/tens/wrap are unaffected by hold.
REQ-019 Clear during hold shall zero the live count but not the display latch.
REQ-020 Refresh prescaler: 16-bit counter 0..REFRESH_DIV-1, wraps to 0; on wrap the digit select sel toggles.
REQ-021 sel=0: an=2'b10, seg=decode(disp_ones); sel=1: an=2'b01, seg=decode(disp_tens); an and seg shall be registered and change in the same cycle.
REQ-022 Decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code = 1111111.
REQ-023 Exactly one an bit shall be low in every cycle after reset.

Reset
REQ-024 While reset=0: ones=0, tens=0, wrap=0, ovf_d=0, display latch=00, prescaler=0, sel=0, an=2'b10, seg=7'b1000000.
REQ-025 Reset asserted mid-count or mid-scan shall override all activity without glitching to any other value; the first event is counted at the first rising edge of ovf_in after reset deasserts.
REQ-026 If ovf_in is already high when reset deasserts, the first active edge shall count one event (ovf_d reset value is 0).

Verification
REQ-027 Single pulse: reset, then ovf_in high 1 cycle -> ones=1 exactly one edge later, tens=0, wrap=0.
REQ-028 Long level: ovf_in high 20 cycles -> count advances by exactly 1.
REQ-029 Rollover: 99 pulses -> tens=9, ones=9; 100th pulse -> 00 with wrap high exactly one cycle.
REQ-030 Clear collision: count=37, clear and ovf_in rise in the same cycle -> 00 next edge, wrap=0, no later increment while ovf_in stays high.
REQ-031 Hold: count=12, hold=1, 5 pulses -> ones/tens=17, displayed digits stay 1 and 2; hold=0 -> displayed 1 and 7 next cycle.
REQ-032 Scan: REFRESH_DIV=4, count=05 -> an alternates 10/01 every 4 cycles, seg=0010010 with an=10, seg=1000000 with an=01; async reset mid-scan -> an=10, seg=1000000 immediately.
